ks_add_issue: RTL

//  Initiator/controller for the multi-cycle ks_add Kogge-Stone adder. Accepts operand

---
 rtl/ks_add_issue_pkg.sv | 15 +
 rtl/ks_add_issue_if.sv | 25 ++
 rtl/ks_add_issue_add.sv | 51 +++++
 rtl/ks_add_issue.sv | 107 ++++++++++
 4 files changed

// File: rtl/ks_add_issue_pkg.sv
// Shared types and helpers for the ks_add issue controller and its bench.
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ks_issue_state_t;

  // en-high cycles the iterative Kogge-Stone adder needs: one G/P setup plus one per level.
  function automatic int unsigned ks_lat(int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ks_add_issue_if.sv
// Request/result handshake bundle between a datapath client and ks_add_issue.
interface ks_add_issue_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned TAG_W = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [TAG_W-1:0] op_tag;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_sum;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output op_valid, op_a, op_b, op_tag, res_ready,
    input  op_ready, res_valid, res_sum, res_tag
  );

  modport slave (
    input  op_valid, op_a, op_b, op_tag, res_ready,
    output op_ready, res_valid, res_sum, res_tag
  );
endinterface

// File: rtl/ks_add_issue_add.sv
// Iterative Kogge-Stone adder: first en cycle forms G/P, each further en cycle applies
// one prefix level. Operands must be held stable; the sum holds while en is low.
module ks_add #(
  parameter int unsigned N = 64
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);
  localparam int unsigned LVLS = $clog2(N);
  localparam int unsigned LW   = $clog2(LVLS + 2);

  logic [LW-1:0] r_lvl;
  logic [N-1:0]  r_g;
  logic [N-1:0]  r_p;
  logic [N-1:0]  r_x;
  logic [31:0]   w_dist;
  logic [N-1:0]  w_g_sh;
  logic [N-1:0]  w_p_sh;

  assign w_dist = 32'd1 << (r_lvl - LW'(1));
  assign w_g_sh = r_g << w_dist;
  // Bits below the span keep their own propagate.
  assign w_p_sh = (r_p << w_dist) | ~({N{1'b1}} << w_dist);
  assign o_sum  = r_x ^ {r_g[N-2:0], 1'b0};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lvl <= '0;
      r_g   <= '0;
      r_p   <= '0;
      r_x   <= '0;
    end else if (i_en) begin
      r_lvl <= r_lvl + LW'(1);
      if (r_lvl == '0) begin
        r_g <= i_a & i_b;
        r_p <= i_a ^ i_b;
        r_x <= i_a ^ i_b;
      end else begin
        r_g <= r_g | (r_p & w_g_sh);
        r_p <= r_p & w_p_sh;
      end
    end else begin
      r_lvl <= '0;
    end
  end

endmodule

// File: rtl/ks_add_issue.sv
// Issue controller for ks_add: holds operands and en for the adder's settle time, then
// presents the tagged sum on a valid/ready result port. One op per LAT+1 cycles.
module ks_add_issue
  import ks_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  ks_add_issue_if.slave io_bus,
  output logic          o_busy,
  output logic [15:0]   o_done_cnt
);
  localparam int unsigned LAT = ks_lat(N);
  localparam int unsigned CW  = $clog2(LAT + 1);

  ks_issue_state_t  r_state;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [TAG_W-1:0] r_tag;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_done_cnt;

  logic             w_done;
  logic             w_res_valid;
  logic             w_op_ready;
  logic             w_op_fire;
  logic             w_res_fire;
  logic             w_en;
  logic             w_rstn;
  logic [N-1:0]     w_sum;

  assign w_done      = (r_state == DONE);
  assign w_res_valid = w_done & ~i_flush;
  // The result slot frees in the same cycle it is consumed.
  assign w_op_ready  = ~i_flush & ((r_state == IDLE) | (w_done & io_bus.res_ready));
  assign w_op_fire   = io_bus.op_valid & w_op_ready;
  assign w_res_fire  = w_res_valid & io_bus.res_ready;
  assign w_en        = (r_state == RUN);
  assign w_rstn      = ~i_rst;

  assign io_bus.op_ready  = w_op_ready;
  assign io_bus.res_valid = w_res_valid;
  assign io_bus.res_sum   = w_res_valid ? w_sum : '0;
  assign io_bus.res_tag   = w_res_valid ? r_tag : '0;
  assign o_busy           = (r_state != IDLE);
  assign o_done_cnt       = r_done_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_cnt      <= '0;
      r_done_cnt <= '0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_op_fire) begin
            r_a     <= io_bus.op_a;
            r_b     <= io_bus.op_b;
            r_tag   <= io_bus.op_tag;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(LAT - 1)) r_state <= DONE;
        end
        DONE: begin
          if (w_res_fire) begin
            r_done_cnt <= r_done_cnt + 16'd1;
            if (w_op_fire) begin
              r_a     <= io_bus.op_a;
              r_b     <= io_bus.op_b;
              r_tag   <= io_bus.op_tag;
              r_cnt   <= '0;
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ks_add #(
    .N(N)
  ) u_add (
    .i_clk  (i_clk),
    .i_rstn (w_rstn),
    .i_en   (w_en),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_sum  (w_sum)
  );

endmodule
